// File: rtl/mips_fetch_pc_unit_if.sv
// Decode-to-fetch bus for the fetch PC unit: control word, operands, redirects
// and the fetch address/flush/stall outputs.
interface mips_fetch_pc_unit_if;
    logic [1:0]  ctl_action;
    logic [1:0]  ctl_condition;
    logic        dec_valid;
    logic [31:0] dec_pc;
    logic [15:0] dec_imm16;
    logic [25:0] dec_index26;
    logic [31:0] rs_value;
    logic [31:0] rt_value;
    logic        rs_ready;
    logic        rt_ready;
    logic        hold;
    logic        exc_valid;
    logic [31:0] exc_pc;
    logic [31:0] fetch_pc;
    logic        fetch_valid;
    logic        flush_ifid;
    logic        stall_dec;
    logic        misaligned;

    modport master (
        output ctl_action, ctl_condition, dec_valid, dec_pc, dec_imm16,
        output dec_index26, rs_value, rt_value, rs_ready, rt_ready,
        output hold, exc_valid, exc_pc,
        input  fetch_pc, fetch_valid, flush_ifid, stall_dec, misaligned
    );

    modport slave (
        input  ctl_action, ctl_condition, dec_valid, dec_pc, dec_imm16,
        input  dec_index26, rs_value, rt_value, rs_ready, rt_ready,
        input  hold, exc_valid, exc_pc,
        output fetch_pc, fetch_valid, flush_ifid, stall_dec, misaligned
    );
endinterface

// File: rtl/mips_fetch_pc_unit.sv
// Fetch PC owner: resolves decode-stage branches/jumps and exception redirects.
// Define MIPS_FETCH_PC_DELAY_SLOT_EN to keep the delay-slot instruction on taken.
module mips_fetch_pc_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
    parameter int          ADDR_W       = 32
) (
    input logic                clk,
    input logic                rst_n,
    mips_fetch_pc_unit_if.slave bus
);

`ifdef MIPS_FETCH_PC_DELAY_SLOT_EN
    localparam bit DELAY_SLOT = 1'b1;
`else
    localparam bit DELAY_SLOT = 1'b0;
`endif

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc_q;
    logic              valid_q;
    logic              mis_q;

    logic [ADDR_W-1:0] seq;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] next_pc;
    logic              need_ops;
    logic              ops_ok;
    logic              taken;
    logic              blocked;
    logic              active;

    assign seq    = bus.dec_pc + 32'd4;
    assign br_tgt = seq + {{14{bus.dec_imm16[15]}}, bus.dec_imm16, 2'b00};
    assign j_tgt  = {seq[31:28], bus.dec_index26, 2'b00};

    always_comb begin
        need_ops = 1'b0;
        ops_ok   = 1'b1;
        taken    = 1'b0;
        target   = seq;
        if (bus.dec_valid) begin
            unique case (bus.ctl_action)
                2'd1: begin
                    taken  = 1'b1;
                    target = j_tgt;
                end
                2'd2: begin
                    need_ops = 1'b1;
                    ops_ok   = bus.rs_ready;
                    taken    = 1'b1;
                    target   = bus.rs_value;
                end
                2'd3: begin
                    target = br_tgt;
                    // Condition 3 is reserved and behaves as an untaken None.
                    unique case (bus.ctl_condition)
                        2'd1: begin
                            need_ops = 1'b1;
                            ops_ok   = bus.rs_ready && bus.rt_ready;
                            taken    = bus.rs_value == bus.rt_value;
                        end
                        2'd2: begin
                            need_ops = 1'b1;
                            ops_ok   = bus.rs_ready && bus.rt_ready;
                            taken    = bus.rs_value != bus.rt_value;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign blocked = need_ops && !ops_ok;
    assign active  = state != BOOT;
    assign next_pc = bus.exc_valid ? bus.exc_pc
                   : taken         ? target
                   :                 pc_q + 32'd4;

    assign bus.stall_dec  = active && !bus.exc_valid
                         && (bus.hold || blocked);
    assign bus.flush_ifid = active && (bus.exc_valid
                         || (!bus.hold && !blocked && taken && !DELAY_SLOT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            unique case (state)
                BOOT: begin
                    valid_q <= 1'b1;
                    state   <= RUN;
                end
                default: begin
                    if (bus.exc_valid) begin
                        pc_q  <= next_pc;
                        mis_q <= next_pc[1:0] != 2'b00;
                        state <= RUN;
                    end else if (bus.hold) begin
                        state <= state;
                    end else if (blocked) begin
                        state <= WAIT;
                    end else begin
                        pc_q  <= next_pc;
                        mis_q <= next_pc[1:0] != 2'b00;
                        state <= RUN;
                    end
                end
            endcase
        end
    end

    assign bus.fetch_pc    = pc_q;
    assign bus.fetch_valid = valid_q;
    assign bus.misaligned  = mis_q;

endmodule

// File: tb/tb_mips_fetch_pc_unit.sv
// Bench for mips_fetch_pc_unit: directed plan steps then random traffic
// against a behavioural model of the fetch PC rules.
module tb_mips_fetch_pc_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [31:0] m_pc;
    logic        m_valid;
    logic        m_mis;
    logic        m_boot;

    mips_fetch_pc_unit_if bus ();

    mips_fetch_pc_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.ctl_action    = 2'd0;
        bus.ctl_condition = 2'd0;
        bus.dec_valid     = 1'b0;
        bus.dec_pc        = 32'h0;
        bus.dec_imm16     = 16'h0;
        bus.dec_index26   = 26'h0;
        bus.rs_value      = 32'h0;
        bus.rt_value      = 32'h0;
        bus.rs_ready      = 1'b1;
        bus.rt_ready      = 1'b1;
        bus.hold          = 1'b0;
        bus.exc_valid     = 1'b0;
        bus.exc_pc        = 32'h0;
    endtask

    task automatic model_reset();
        m_pc    = 32'hBFC0_0000;
        m_valid = 1'b0;
        m_mis   = 1'b0;
        m_boot  = 1'b1;
    endtask

    // One cycle: model decides, comb outputs checked mid-cycle, regs after edge.
    task automatic step(string tag);
        logic        e_flush;
        logic        e_stall;
        logic        load;
        logic [31:0] npc;
        logic [31:0] seq;
        logic        go;
        logic [31:0] tgt;
        logic signed [15:0] simm;
        int          off;
        e_flush = 1'b0;
        e_stall = 1'b0;
        load    = 1'b0;
        npc     = m_pc;
        go      = 1'b0;
        tgt     = 32'h0;
        seq     = bus.dec_pc + 32'd4;
        simm    = bus.dec_imm16;
        off     = simm;
        if (m_boot) begin
            load = 1'b0;
        end else if (bus.exc_valid) begin
            e_flush = 1'b1;
            load    = 1'b1;
            npc     = bus.exc_pc;
        end else if (bus.hold) begin
            e_stall = 1'b1;
        end else begin
            load = 1'b1;
            npc  = m_pc + 32'd4;
            if (bus.dec_valid && bus.ctl_action == 2'd1) begin
                go  = 1'b1;
                tgt = {seq[31:28], bus.dec_index26, 2'b00};
            end else if (bus.dec_valid && bus.ctl_action == 2'd2) begin
                if (!bus.rs_ready) begin
                    e_stall = 1'b1;
                    load    = 1'b0;
                end else begin
                    go  = 1'b1;
                    tgt = bus.rs_value;
                end
            end else if (bus.dec_valid && bus.ctl_action == 2'd3 &&
                         (bus.ctl_condition == 2'd1 ||
                          bus.ctl_condition == 2'd2)) begin
                if (!(bus.rs_ready && bus.rt_ready)) begin
                    e_stall = 1'b1;
                    load    = 1'b0;
                end else if ((bus.rs_value == bus.rt_value) ==
                             (bus.ctl_condition == 2'd1)) begin
                    go  = 1'b1;
                    tgt = seq + 32'(off * 4);
                end
            end
            if (go) begin
                npc = tgt;
`ifndef MIPS_FETCH_PC_DELAY_SLOT_EN
                e_flush = 1'b1;
`endif
            end
        end
        #2;
        chk($sformatf("%s.flush", tag), 32'(bus.flush_ifid), 32'(e_flush));
        chk($sformatf("%s.stall", tag), 32'(bus.stall_dec), 32'(e_stall));
        @(posedge clk);
        if (m_boot) begin
            m_boot  = 1'b0;
            m_valid = 1'b1;
        end else if (load) begin
            m_pc  = npc;
            m_mis = npc[1:0] != 2'b00;
        end
        #1;
        chk($sformatf("%s.pc", tag), bus.fetch_pc, m_pc);
        chk($sformatf("%s.valid", tag), 32'(bus.fetch_valid), 32'(m_valid));
        chk($sformatf("%s.mis", tag), 32'(bus.misaligned), 32'(m_mis));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle();
        model_reset();
        // Stall/flush must stay low in reset even with hold and a waiting JR.
        bus.hold      = 1'b1;
        bus.dec_valid = 1'b1;
        bus.ctl_action = 2'd2;
        bus.rs_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.pc", bus.fetch_pc, 32'hBFC0_0000);
        chk("rst.valid", 32'(bus.fetch_valid), 32'd0);
        chk("rst.stall", 32'(bus.stall_dec), 32'd0);
        chk("rst.flush", 32'(bus.flush_ifid), 32'd0);
        idle();
        rst_n = 1'b1;
        step("boot");
        chk("boot.vec", bus.fetch_pc, 32'hBFC0_0000);
        step("inc1");
        chk("inc1.const", bus.fetch_pc, 32'hBFC0_0004);
        step("inc2");
        chk("inc2.const", bus.fetch_pc, 32'hBFC0_0008);

        bus.dec_valid     = 1'b1;
        bus.ctl_action    = 2'd3;
        bus.ctl_condition = 2'd1;
        bus.dec_pc        = 32'h0040_0010;
        bus.dec_imm16     = 16'hFFFC;
        bus.rs_value      = 32'd5;
        bus.rt_value      = 32'd5;
        step("beq_t");
        chk("beq_t.const", bus.fetch_pc, 32'h0040_0004);
        bus.rt_value = 32'd6;
        step("beq_nt");
        chk("beq_nt.const", bus.fetch_pc, 32'h0040_0008);

        bus.ctl_action = 2'd2;
        bus.rs_ready   = 1'b0;
        bus.rs_value   = 32'h0040_0103;
        step("jalr_w1");
        step("jalr_w2");
        bus.rs_ready = 1'b1;
        step("jalr_go");
        chk("jalr_go.const", bus.fetch_pc, 32'h0040_0103);
        chk("jalr_go.mis1", 32'(bus.misaligned), 32'd1);

        bus.ctl_action  = 2'd1;
        bus.dec_pc      = 32'hF000_0010;
        bus.dec_index26 = 26'h012_3456;
        bus.hold        = 1'b1;
        step("j_hold");
        chk("j_hold.const", bus.fetch_pc, 32'h0040_0103);
        bus.hold = 1'b0;
        step("j_go");
        chk("j_go.const", bus.fetch_pc, 32'hF048_D158);

        bus.ctl_action = 2'd2;
        bus.rs_ready   = 1'b0;
        step("exc_wait");
        bus.hold      = 1'b1;
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h8000_0180;
        step("exc");
        chk("exc.const", bus.fetch_pc, 32'h8000_0180);
        idle();
        step("exc_after");

        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'hFFFF_FFFC;
        step("wrap_set");
        bus.exc_valid = 1'b0;
        step("wrap");
        chk("wrap.const", bus.fetch_pc, 32'h0000_0000);

        bus.dec_valid  = 1'b1;
        bus.ctl_action = 2'd2;
        bus.rs_ready   = 1'b0;
        step("rst_wait");
        rst_n = 1'b0;
        #1;
        chk("async.pc", bus.fetch_pc, 32'hBFC0_0000);
        chk("async.valid", 32'(bus.fetch_valid), 32'd0);
        chk("async.stall", 32'(bus.stall_dec), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        idle();
        rst_n = 1'b1;
        step("reboot");

        for (int i = 0; i < 400; i++) begin
            bus.dec_valid     = $urandom_range(0, 3) != 0;
            bus.ctl_action    = 2'($urandom_range(0, 3));
            bus.ctl_condition = 2'($urandom_range(0, 3));
            bus.dec_pc        = $urandom & 32'hFFFF_FFFC;
            bus.dec_imm16     = 16'($urandom);
            bus.dec_index26   = 26'($urandom);
            if ($urandom_range(0, 1) != 0) begin
                bus.rs_value = 32'($urandom_range(0, 3));
                bus.rt_value = 32'($urandom_range(0, 3));
            end else begin
                bus.rs_value = $urandom;
                bus.rt_value = $urandom;
            end
            bus.rs_ready  = $urandom_range(0, 3) != 0;
            bus.rt_ready  = $urandom_range(0, 3) != 0;
            bus.hold      = $urandom_range(0, 7) == 0;
            bus.exc_valid = $urandom_range(0, 15) == 0;
            bus.exc_pc    = $urandom;
            step($sformatf("rnd%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_fetch_pc_unit.md
Name: mips_fetch_pc_unit

Overview:
- Consumes the IF/ID PC control word (action + condition) produced by the decode-stage PC signal generator.
- Resolves branches and jumps in decode and owns the architectural fetch PC register.
- Drives the instruction-fetch address, the IF/ID flush and the decode stall.
- Handles operand-not-ready waits for register-dependent control flow and exception redirects from later stages.

Parameters:
- RESET_VECTOR, 32'hBFC0_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width; only 32 is supported.

Ports:
- clk  input  1  clock (rising edge)
- rst_n  input  1  asynchronous active-low reset
- ctl_action  input  2  PC action: 0=Inc, 1=Jump, 2=JumpR, 3=Branch
- ctl_condition  input  2  branch condition: 0=None, 1=EQ, 2=NE, 3=reserved (treated as None)
- dec_valid  input  1  IF/ID holds a valid instruction
- dec_pc  input  32  PC of the decode-stage instruction
- dec_imm16  input  16  branch offset field
- dec_index26  input  26  jump index field
- rs_value  input  32  forwarded rs operand
- rt_value  input  32  forwarded rt operand
- rs_ready  input  1  rs_value is valid this cycle
- rt_ready  input  1  rt_value is valid this cycle
- hold  input  1  external stall (icache miss / back-pressure)
- exc_valid  input  1  exception redirect request from a later stage
- exc_pc  input  32  exception handler address
- fetch_pc  output  32  current fetch address (registered)
- fetch_valid  output  1  fetch_pc is a valid request
- flush_ifid  output  1  kill the instruction entering IF/ID
- stall_dec  output  1  decode must hold its instruction
- misaligned  output  1  fetch_pc[1:0] != 0 (registered alongside fetch_pc)

Behaviour:
- Reset (async): fetch_pc=RESET_VECTOR, fetch_valid=0, misaligned=0, state=BOOT. flush_ifid and stall_dec read 0 while in reset.
- States: BOOT, RUN, WAIT.
  - BOOT: fetch_valid goes 1 on the first edge after reset release; fetch_pc stays RESET_VECTOR; go to RUN.
  - RUN: normal operation.
  - WAIT: operands not ready for a control instruction.
- Targets, computed combinationally from dec_pc:
  - seq = dec_pc+4.
  - branch target = seq + (sign_extend(dec_imm16)<<2), modulo 2^32.
  - jump target = {seq[31:28], dec_index26, 2'b00}.
  - JumpR target = rs_value.
- need_ops when dec_valid and either:
  - action=JumpR: needs rs_ready; or
  - action=Branch with EQ/NE: needs rs_ready && rt_ready.
  - Branch with None never needs operands and is never taken.
- taken when dec_valid and either:
  - action is Jump or JumpR; or
  - action=Branch and (EQ: rs==rt; NE: rs!=rt).
- Priority, highest first, evaluated each cycle in RUN/WAIT:
  - exc_valid: fetch_pc<=exc_pc; flush_ifid=1; state<=RUN. Ignores hold and WAIT.
  - hold: all registers hold; stall_dec=1; flush_ifid=0.
  - need_ops with operands not ready: state<=WAIT; stall_dec=1; fetch_pc held.
  - taken: fetch_pc<=target (see Optional Feature for flush).
  - otherwise: fetch_pc<=fetch_pc+4 (wraps 32'hFFFF_FFFC -> 0).
- WAIT exits to RUN on the cycle operands become ready. The decision is taken that same cycle, so latency from ready to redirect is 0 extra cycles.
- dec_valid=0 in WAIT returns to RUN.
- Redirect latency: the taken decision in cycle N gives fetch_pc=target after edge N.
- misaligned is computed from the next fetch_pc value; the PC is loaded regardless.
- An unaligned JumpR target is not corrected.

Optional Feature:
- Macro: MIPS_FETCH_PC_DELAY_SLOT_EN.
- Defined: architectural delay slot. On a taken branch/jump, flush_ifid=0; the instruction at dec_pc+4 already fetched executes.
- Undefined: on taken, flush_ifid=1 for that cycle, squashing the fetched sequential instruction.
- exc_valid flushes in both builds.

Test Plan:
- Reset release with rst_n low 3 cycles -> fetch_pc=BFC00000, fetch_valid 0 then 1 after first edge; then BFC00004, BFC00008.
- BEQ in decode: dec_pc=00400010, imm16=FFFC, rs=rt=5, ready -> next fetch_pc=00400004. flush_ifid=0 with macro, 1 without. Repeat with rs!=rt -> fetch_pc increments.
- JALR: action=JumpR, rs_ready=0 for 2 cycles then rs_value=00400103 -> stall_dec=1 for 2 cycles, fetch_pc held. Then fetch_pc=00400103, misaligned=1.
- hold=1 and taken Jump simultaneously -> no PC change. Release hold -> jump target {dec_pc+4[31:28], index, 00} loaded.
- exc_valid=1, exc_pc=80000180 while in WAIT with hold=1 -> fetch_pc=80000180, flush_ifid=1, state RUN.
- fetch_pc=FFFFFFFC with Inc -> wraps to 00000000. rst_n asserted mid-WAIT -> immediate fetch_pc=BFC00000, fetch_valid=0.
